fifo_rd_ctrl: RTL and testbench

Read-domain pointer and status controller for the async FIFO. It consumes the write pointer after the two-flop synchronizer has brought it into the read clock domain. It also generates the Gray-coded read pointer that the write domain synchronizes back. It produces the RAM read address, the empty and almost-empty flags, a conservative occupancy count, read-data-valid and underflow indications.

---
 rtl/fifo_rd_ctrl_pkg.sv | 21 ++
 rtl/fifo_rd_ctrl_gray2bin.sv | 17 +
 rtl/fifo_rd_ctrl.sv | 78 +++++++
 tb/tb_fifo_rd_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO read and write controllers.
// Functions work on a 32-bit container; callers zero-extend and truncate to their pointer width.
package fifo_rd_ctrl_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended Gray input keeps the prefix XOR correct for any narrower width.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter (MSB-first XOR prefix).
module fifo_rd_ctrl_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    always_comb begin
        o_bin = '0;
        o_bin[W-1] = i_gray[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            o_bin[i] = o_bin[i+1] ^ i_gray[i];
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/status controller for the async FIFO.
// Consumes the synchronized Gray write pointer and produces the Gray read pointer, RAM address and status flags.
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH:0]   wptr_sync,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic                  rd_valid,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rgray;
    logic          r_empty;
    logic          r_almost_empty;
    logic [PW-1:0] r_rd_count;
    logic          r_rd_valid;
    logic          r_underflow;

    logic          w_accept;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_count_next;

    fifo_rd_ctrl_gray2bin #(.W(PW)) u_wptr_g2b (
        .i_gray (wptr_sync),
        .o_bin  (w_wbin)
    );

    // Gate on the registered empty so a read of the last word is never double-counted.
    assign w_accept     = rd_en & ~r_empty;
    assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_accept};
    assign w_rgray_next = PW'(bin2gray(PTR_MAX_W'(w_rbin_next)));
    assign w_count_next = w_wbin - w_rbin_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbin         <= '0;
            r_rgray        <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_count     <= '0;
            r_rd_valid     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rgray        <= w_rgray_next;
            r_empty        <= (w_rgray_next == wptr_sync);
            r_almost_empty <= (w_count_next <= AE_LIMIT);
            r_rd_count     <= w_count_next;
            r_rd_valid     <= w_accept;
            r_underflow    <= rd_en & r_empty;
        end
    end

    assign rptr         = r_rgray;
    assign raddr        = r_rbin[ADDR_WIDTH-1:0];
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign rd_count     = r_rd_count;
    assign rd_valid     = r_rd_valid;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus random traffic against a read/write counting model.
module tb_fifo_rd_ctrl;

    localparam int AW = 4;
    localparam int PW = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rd_en = 1'b0;
    logic [PW-1:0] wptr_sync = '0;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_count;
    logic          rd_valid;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Model: total words made visible to the read side and total words read.
    int m_writes = 0;
    int m_reads  = 0;
    bit m_empty  = 1'b1;

    fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AE_THRESH(AE)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rd_en        (rd_en),
        .wptr_sync    (wptr_sync),
        .rptr         (rptr),
        .raddr        (raddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_count     (rd_count),
        .rd_valid     (rd_valid),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] to_gray(input int count);
        logic [PW-1:0] b;
        b = count[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".rptr"},         32'(rptr),         32'd0);
        chk({tag, ".raddr"},        32'(raddr),        32'd0);
        chk({tag, ".empty"},        32'(empty),        32'd1);
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
        chk({tag, ".rd_count"},     32'(rd_count),     32'd0);
        chk({tag, ".rd_valid"},     32'(rd_valid),     32'd0);
        chk({tag, ".underflow"},    32'(underflow),    32'd0);
    endtask

    // One clock: present rd and newly visible writes, then compare every output to the model.
    task automatic step(input string tag, input bit rd, input int add);
        bit acc;
        bit und;
        int occ;
        rd_en = rd;
        m_writes += add;
        wptr_sync = to_gray(m_writes);
        acc = rd && !m_empty;
        und = rd && m_empty;
        @(posedge clk);
        #1;
        m_reads += acc ? 1 : 0;
        occ = m_writes - m_reads;
        m_empty = (occ == 0);
        chk({tag, ".rptr"},         32'(rptr),         32'(to_gray(m_reads)));
        chk({tag, ".raddr"},        32'(raddr),        32'(m_reads % DEPTH));
        chk({tag, ".empty"},        32'(empty),        32'(m_empty));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(occ <= AE));
        chk({tag, ".rd_count"},     32'(rd_count),     32'(occ));
        chk({tag, ".rd_valid"},     32'(rd_valid),     32'(acc));
        chk({tag, ".underflow"},    32'(underflow),    32'(und));
    endtask

    initial begin
        int add;

        // Reset held across several edges.
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        resetn = 1'b1;

        // Fill three words then drain them.
        step("fill3", 1'b0, 3);
        chk("fill3.count_lit", 32'(rd_count), 32'd3);
        step("drain1", 1'b1, 0);
        chk("drain1.rptr_lit", 32'(rptr), 32'b00001);
        step("drain2", 1'b1, 0);
        chk("drain2.rptr_lit", 32'(rptr), 32'b00011);
        step("drain3", 1'b1, 0);
        chk("drain3.rptr_lit", 32'(rptr), 32'b00010);
        chk("drain3.raddr_lit", 32'(raddr), 32'd3);
        step("idle", 1'b0, 0);

        // Underflow: single pulse, pointer held.
        step("uflow", 1'b1, 0);
        step("uflow_clr", 1'b0, 0);

        // Walk the read pointer up to 31 with one word left past the wrap.
        step("wrapfill_a", 1'b0, 14);
        for (int i = 0; i < 14; i++) step("wrapread_a", 1'b1, 0);
        step("wrapfill_b", 1'b0, 14);
        for (int i = 0; i < 14; i++) step("wrapread_b", 1'b1, 0);
        chk("wrap.rptr31", 32'(rptr), 32'b10000);
        step("wrapfill_c", 1'b0, 1);
        chk("wrap.wptr0", 32'(wptr_sync), 32'b00000);
        step("wrapread_c", 1'b1, 0);
        chk("wrap.rptr0", 32'(rptr), 32'b00000);
        chk("wrap.empty", 32'(empty), 32'd1);

        // Full buffer, then almost-empty boundary.
        step("full", 1'b0, DEPTH);
        chk("full.count16", 32'(rd_count), 32'd16);
        for (int i = 0; i < 12; i++) step("drain_to4", 1'b1, 0);
        chk("ae.occ4", 32'(almost_empty), 32'd0);
        step("ae_r1", 1'b1, 0);
        step("ae_r2", 1'b1, 0);
        chk("ae.occ2", 32'(almost_empty), 32'd1);
        chk("ae.nonempty", 32'(empty), 32'd0);

        // Last word read while a new word arrives.
        step("last_plus_new", 1'b1, 0);
        step("last_plus_new", 1'b1, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            add = $urandom_range(0, 2);
            if (m_writes + add - m_reads > DEPTH) add = DEPTH - (m_writes - m_reads);
            step("rand", 1'($urandom_range(0, 1)), add);
        end

        // Async reset mid-read with five words outstanding.
        for (int i = 0; i < 40 && !m_empty; i++) step("predrain", 1'b1, 0);
        step("occ5", 1'b0, 5);
        rd_en = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        check_reset("async_rst");
        m_writes = 0;
        m_reads = 0;
        m_empty = 1'b1;
        wptr_sync = '0;
        @(posedge clk);
        #1;
        check_reset("async_rst_hold");
        @(negedge clk);
        resetn = 1'b1;
        step("post_rst", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
